// File: rtl/barrett_pkg.sv
// -----------------------------------------------------------------------------
// barrett_pkg
// Shared helpers for the multi-modulus Barrett reduction pipeline:
//   - MAX_K            : widest modulus the elaboration-time helpers support
//   - barrett_sel_bits : width of the modulus-select field for N moduli
//   - barrett_u        : Barrett constant U = floor(2^(2k) / p), elaboration only
// -----------------------------------------------------------------------------
package barrett_pkg;

  localparam int MAX_K = 512;

  // A single modulus still needs a 1-bit select so the port never collapses.
  function automatic int barrett_sel_bits(input int n);
    int bits;
    if (n <= 2) begin
      bits = 1;
    end else begin
      bits = $clog2(n);
    end
    return bits;
  endfunction

  // Restoring long division of 2^(2k) by p. The dividend is a single 1
  // followed by 2k zeros, so it is fed in bit by bit rather than stored.
  function automatic logic [MAX_K:0] barrett_u(input logic [MAX_K-1:0] p, input int k);
    logic [MAX_K:0] rem;
    logic [MAX_K:0] quo;
    rem = '0;
    quo = '0;
    for (int i = 2 * k; i >= 0; i--) begin
      rem = {rem[MAX_K-1:0], (i == 2 * k) ? 1'b1 : 1'b0};
      if (rem >= {1'b0, p}) begin
        rem = rem - {1'b0, p};
        if (i <= MAX_K) begin
          quo[i] = 1'b1;
        end
      end
    end
    return quo;
  endfunction

endpackage

// File: rtl/barrett_mult_pipe.sv
// -----------------------------------------------------------------------------
// barrett_mult_pipe
// Fixed-latency pipelined multiplier with a global advance enable. The full
// A_BITS x B_BITS product is formed, and only the window
// [OUT_LSB +: OUT_BITS] is kept, then delayed through LAT register stages.
// Ports:
//   clk  in   clock
//   en   in   advance enable; all stages hold when low
//   a    in   A_BITS multiplicand
//   b    in   B_BITS multiplier
//   p    out  OUT_BITS product window, valid LAT enabled cycles after a/b
// -----------------------------------------------------------------------------
module barrett_mult_pipe #(
  parameter int A_BITS   = 9,
  parameter int B_BITS   = 9,
  parameter int LAT      = 3,
  parameter int OUT_LSB  = 0,
  parameter int OUT_BITS = 18
) (
  input  logic                clk,
  input  logic                en,
  input  logic [A_BITS-1:0]   a,
  input  logic [B_BITS-1:0]   b,
  output logic [OUT_BITS-1:0] p
);

  localparam int W = A_BITS + B_BITS;

  logic [W-1:0]        a_ext;
  logic [W-1:0]        b_ext;
  logic [OUT_BITS-1:0] stage [LAT];

  assign a_ext = {{B_BITS{1'b0}}, a};
  assign b_ext = {{A_BITS{1'b0}}, b};

  // Product window capture followed by a plain delay chain.
  always_ff @(posedge clk) begin
    if (en) begin
      stage[0] <= OUT_BITS'((a_ext * b_ext) >> OUT_LSB);
      for (int i = 1; i < LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign p = stage[LAT-1];

endmodule

// File: rtl/barrett_mod_multi_pipe.sv
// -----------------------------------------------------------------------------
// barrett_mod_multi_pipe
// Pipelined Barrett reduction of a 2k-bit x to x mod P_sel, with P_sel chosen
// per transaction from N_MOD elaboration-time moduli. One result per cycle,
// latency 2*MULT_LAT+3, in-order, whole pipe stalls on i_rdy low.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_dat/i_sel/i_ctl     operand x (< P_sel^2), modulus index, sideband tag
//   i_val / o_rdy         input handshake (o_rdy is combinational)
//   o_dat/o_ctl           x mod P_sel and the matching tag
//   o_val / i_rdy         output handshake
//   o_err                 sticky: bad select accepted or result not reduced
//   o_cnt_out/o_cnt_corr  delivered / corrected result counters
// Optional feature: define BARRETT_MOD_STATS_EN to build the counters;
// otherwise both counter ports read 0.
// -----------------------------------------------------------------------------
module barrett_mod_multi_pipe
  import barrett_pkg::*;
#(
  parameter int DAT_BITS = 256,
  parameter int CTL_BITS = 8,
  parameter int N_MOD    = 2,
  parameter logic [N_MOD*DAT_BITS-1:0] P_TABLE = {
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141,
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
  },
  parameter int MULT_LAT = 3,
  localparam int SEL_BITS = barrett_sel_bits(N_MOD)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [2*DAT_BITS-1:0] i_dat,
  input  logic [SEL_BITS-1:0]   i_sel,
  input  logic [CTL_BITS-1:0]   i_ctl,
  input  logic                  i_val,
  output logic                  o_rdy,
  output logic [DAT_BITS-1:0]   o_dat,
  output logic [CTL_BITS-1:0]   o_ctl,
  output logic                  o_val,
  input  logic                  i_rdy,
  output logic                  o_err,
  output logic [31:0]           o_cnt_out,
  output logic [31:0]           o_cnt_corr
);

  localparam int K  = DAT_BITS;
  localparam int DL = 2 * MULT_LAT;

  // Side data that rides alongside the two multipliers.
  typedef struct packed {
    logic [K:0]          x_lo;
    logic [SEL_BITS-1:0] sel;
    logic [CTL_BITS-1:0] ctl;
  } dl_t;

  logic [K-1:0] p_tab [N_MOD];
  logic [K:0]   u_tab [N_MOD];

  for (genvar j = 0; j < N_MOD; j++) begin : g_tab
    localparam logic [MAX_K:0] U_FULL = barrett_u(MAX_K'(P_TABLE[j*K +: K]), K);
    assign p_tab[j] = P_TABLE[j*K +: K];
    assign u_tab[j] = U_FULL[K:0];
  end

  logic                en;
  logic                acc;
  logic                sel_bad;
  logic [SEL_BITS-1:0] sel_in;

  logic                s0_val;
  logic [2*K-1:0]      s0_x;
  logic [SEL_BITS-1:0] s0_sel;
  logic [CTL_BITS-1:0] s0_ctl;

  logic [DL-1:0]       dl_val;
  dl_t                 dl [DL];

  logic [K:0]          q3;
  logic [K:0]          m_lo;
  logic [K:0]          u_a;
  logic [K-1:0]        p_b;

  logic                sub_val;
  logic [K:0]          sub_r;
  logic [SEL_BITS-1:0] sub_sel;
  logic [CTL_BITS-1:0] sub_ctl;

  logic [K:0]          p_c;
  logic [K:0]          r1;
  logic [K:0]          r2;
  logic                need_corr;
  logic                still_big;

  // The whole pipe advances together; a held output freezes every slot.
  assign en      = ~o_val | i_rdy;
  assign o_rdy   = en;
  assign acc     = i_val & en;
  assign sel_bad = (i_sel > SEL_BITS'(N_MOD - 1));

  // Out-of-range selects fall back to modulus 0.
  always_comb begin
    sel_in = i_sel;
    if (sel_bad) begin
      sel_in = '0;
    end else begin
      sel_in = i_sel;
    end
  end

  assign u_a = u_tab[s0_sel];
  assign p_b = p_tab[dl[MULT_LAT-1].sel];

  // Mult A: q3 = ((x >> (k-1)) * U) >> (k+1)
  barrett_mult_pipe #(
    .A_BITS  (K + 1),
    .B_BITS  (K + 1),
    .LAT     (MULT_LAT),
    .OUT_LSB (K + 1),
    .OUT_BITS(K + 1)
  ) u_mult_a (
    .clk(i_clk),
    .en (en),
    .a  (s0_x[2*K-1:K-1]),
    .b  (u_a),
    .p  (q3)
  );

  // Mult B: low k+1 bits of q3 * P are all the subtraction needs.
  barrett_mult_pipe #(
    .A_BITS  (K + 1),
    .B_BITS  (K),
    .LAT     (MULT_LAT),
    .OUT_LSB (0),
    .OUT_BITS(K + 1)
  ) u_mult_b (
    .clk(i_clk),
    .en (en),
    .a  (q3),
    .b  (p_b),
    .p  (m_lo)
  );

  // Two cascaded conditional subtractions; a third would-be correction is an error.
  always_comb begin
    p_c       = {1'b0, p_tab[sub_sel]};
    need_corr = (sub_r >= p_c);
    r1        = sub_r;
    r2        = sub_r;
    if (need_corr) begin
      r1 = sub_r - p_c;
    end else begin
      r1 = sub_r;
    end
    if (r1 >= p_c) begin
      r2 = r1 - p_c;
    end else begin
      r2 = r1;
    end
    still_big = (r2 >= p_c);
  end

  // Valid chain and sticky error; these are the only reset state besides counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s0_val  <= 1'b0;
      dl_val  <= '0;
      sub_val <= 1'b0;
      o_val   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      if (en) begin
        s0_val  <= i_val;
        dl_val  <= {dl_val[DL-2:0], s0_val};
        sub_val <= dl_val[DL-1];
        o_val   <= sub_val;
      end
      if ((acc & sel_bad) | (en & sub_val & still_big)) begin
        o_err <= 1'b1;
      end
    end
  end

  // Data path registers; contents are qualified by the valid chain, so no reset.
  always_ff @(posedge i_clk) begin
    if (en) begin
      s0_x    <= i_dat;
      s0_sel  <= sel_in;
      s0_ctl  <= i_ctl;
      dl[0]   <= '{x_lo: s0_x[K:0], sel: s0_sel, ctl: s0_ctl};
      for (int i = 1; i < DL; i++) begin
        dl[i] <= dl[i-1];
      end
      // Wraps mod 2^(k+1) by construction of the operand widths.
      sub_r   <= dl[DL-1].x_lo - m_lo;
      sub_sel <= dl[DL-1].sel;
      sub_ctl <= dl[DL-1].ctl;
      o_dat   <= r2[K-1:0];
      o_ctl   <= sub_ctl;
    end
  end

`ifdef BARRETT_MOD_STATS_EN
  logic        out_corr;
  logic [31:0] cnt_out;
  logic [31:0] cnt_corr;

  // Correction flag travels with the result it describes.
  always_ff @(posedge i_clk) begin
    if (en) begin
      out_corr <= need_corr;
    end
  end

  // Delivery counters, free-running with natural 32-bit wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_out  <= 32'd0;
      cnt_corr <= 32'd0;
    end else if (o_val & i_rdy) begin
      cnt_out <= cnt_out + 32'd1;
      if (out_corr) begin
        cnt_corr <= cnt_corr + 32'd1;
      end
    end
  end

  assign o_cnt_out  = cnt_out;
  assign o_cnt_corr = cnt_corr;
`else
  assign o_cnt_out  = 32'd0;
  assign o_cnt_corr = 32'd0;
`endif

endmodule
